// File: rtl/dcache_wb_if.sv
// Line-transfer bus between the data cache and the backing memory.
// One blocking transaction at a time: a 128-bit write-back or a 128-bit fill.
interface dcache_wb_if;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache fed by the store buffer.
// Loads and drained stores share one IDLE/WB/FILL controller and one memory port.
module dcache_wb #(
  parameter int LINES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  input  logic        sb_valid,
  input  logic [63:0] sb_entry,
  output logic        sb_ready,
  dcache_wb_if.master mem
);
  localparam int IDX  = $clog2(LINES);
  localparam int TAGW = 28 - IDX;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [LINES-1:0] valid_reg;
  logic [LINES-1:0] dirty_reg;
  logic [TAGW-1:0]  tag_reg  [LINES];
  logic [31:0]      data_reg [LINES][4];

  logic         st_pend_reg;
  logic [31:2]  st_addr_reg;
  logic [31:0]  st_data_reg;
  logic [31:4]  fill_line_reg;
  logic         ld_valid_reg;
  logic [31:0]  ld_data_reg;
  logic [31:0]  mem_addr_reg;
  logic [127:0] mem_wdata_reg;

  logic            acc_active;
  logic [31:2]     acc_addr;
  logic [1:0]      acc_word;
  logic [IDX-1:0]  acc_idx;
  logic [TAGW-1:0] acc_tag;
  logic            acc_hit;
  logic [IDX-1:0]  fill_idx;
  logic [127:0]    victim_line;

  logic st_accept, st_hit, ld_hit, miss_wb, miss_fill, wb_done, fill_done;
  logic unused_bits;

  // The pending store always wins, which keeps loads younger than every accepted
  // store. A load is not re-evaluated in the cycle its result is presented.
  assign acc_active = st_pend_reg || (ld_req && !ld_valid_reg);
  assign acc_addr   = st_pend_reg ? st_addr_reg : ld_addr[31:2];
  assign acc_word   = acc_addr[3:2];
  assign acc_idx    = acc_addr[IDX+3:4];
  assign acc_tag    = acc_addr[31:IDX+4];
  assign acc_hit    = valid_reg[acc_idx] && (tag_reg[acc_idx] == acc_tag);
  assign fill_idx   = fill_line_reg[IDX+3:4];

  assign sb_ready  = (state_reg == IDLE) && !st_pend_reg && !ld_req;
  assign st_accept = sb_valid && sb_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_victim
      assign victim_line[gi*32 +: 32] = data_reg[acc_idx][gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    st_hit     = 1'b0;
    ld_hit     = 1'b0;
    miss_wb    = 1'b0;
    miss_fill  = 1'b0;
    wb_done    = 1'b0;
    fill_done  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (acc_active) begin
          if (acc_hit) begin
            if (st_pend_reg) st_hit = 1'b1;
            else             ld_hit = 1'b1;
          end else if (valid_reg[acc_idx] && dirty_reg[acc_idx]) begin
            miss_wb    = 1'b1;
            state_next = WB;
          end else begin
            miss_fill  = 1'b1;
            state_next = FILL;
          end
        end
      end
      WB: begin
        if (mem.mem_ack) begin
          wb_done    = 1'b1;
          state_next = FILL;
        end
      end
      FILL: begin
        if (mem.mem_ack) begin
          fill_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg     <= '0;
      dirty_reg     <= '0;
      st_pend_reg   <= 1'b0;
      ld_valid_reg  <= 1'b0;
      ld_data_reg   <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      ld_valid_reg <= ld_hit;
      if (ld_hit) ld_data_reg <= data_reg[acc_idx][acc_word];
      if (st_accept) st_pend_reg <= 1'b1;
      if (st_hit) begin
        st_pend_reg        <= 1'b0;
        dirty_reg[acc_idx] <= 1'b1;
      end
      if (miss_wb) begin
        mem_addr_reg  <= {tag_reg[acc_idx], acc_idx, 4'b0000};
        mem_wdata_reg <= victim_line;
      end
      if (miss_fill) mem_addr_reg <= {acc_addr[31:4], 4'b0000};
      // The fill target is remembered at miss time so the WB->FILL hop does not
      // depend on the requester still presenting its address.
      if (wb_done) begin
        dirty_reg[fill_idx] <= 1'b0;
        mem_addr_reg        <= {fill_line_reg, 4'b0000};
      end
      if (fill_done) begin
        valid_reg[fill_idx] <= 1'b1;
        dirty_reg[fill_idx] <= 1'b0;
      end
    end
  end

  // Tag/data storage and the store/fill holding registers carry no reset value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (st_accept) begin
        st_addr_reg <= sb_entry[63:34];
        st_data_reg <= sb_entry[31:0];
      end
      if (miss_wb || miss_fill) fill_line_reg <= acc_addr[31:4];
      if (st_hit) data_reg[acc_idx][acc_word] <= st_data_reg;
      if (fill_done) begin
        tag_reg[fill_idx] <= fill_line_reg[31:IDX+4];
        for (int k = 0; k < 4; k++) begin
          data_reg[fill_idx][k] <= mem.mem_rdata[32*k +: 32];
        end
      end
    end
  end

  assign ld_valid      = ld_valid_reg;
  assign ld_data       = ld_data_reg;
  assign mem.mem_req   = (state_reg != IDLE);
  assign mem.mem_we    = (state_reg == WB);
  assign mem.mem_addr  = mem_addr_reg;
  assign mem.mem_wdata = mem_wdata_reg;

  // Byte-offset bits are don't-care: every access is a full word.
  assign unused_bits = ^{ld_addr[1:0], sb_entry[33:32]};
endmodule

// File: tb/tb_dcache_wb.sv
// Bench for dcache_wb: flat word-memory reference, per-cycle compare process,
// directed scenarios with literal expectations, then randomized load/store traffic.
module tb_dcache_wb;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ld_req = 1'b0;
  logic [31:0]  ld_addr = '0;
  logic         ld_valid;
  logic [31:0]  ld_data;
  logic         sb_valid = 1'b0;
  logic [63:0]  sb_entry = '0;
  logic         sb_ready;

  dcache_wb_if mif();

  dcache_wb #(.LINES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .ld_req   (ld_req),
    .ld_addr  (ld_addr),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .sb_valid (sb_valid),
    .sb_entry (sb_entry),
    .sb_ready (sb_ready),
    .mem      (mif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Backing memory (by line) and program-order word memory (by word address).
  logic [127:0] bmem    [logic [31:0]];
  logic [31:0]  ref_mem [logic [31:0]];

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } txn_t;
  txn_t txn_q[$];

  int lat_fixed  = 3;
  bit resp_hold  = 1'b0;
  bit inject_ack = 1'b0;

  function automatic logic [31:0] init_word(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [127:0] line_of(logic [31:0] la);
    logic [127:0] l;
    if (bmem.exists(la)) return bmem[la];
    for (int k = 0; k < 4; k++) l[32*k +: 32] = init_word(la + 32'(4*k));
    return l;
  endfunction

  function automatic logic [31:0] ref_word(logic [31:0] a);
    logic [31:0]  w;
    logic [127:0] l;
    w = {a[31:2], 2'b00};
    if (ref_mem.exists(w)) return ref_mem[w];
    l = line_of({w[31:4], 4'b0000});
    return l[32*w[3:2] +: 32];
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: no response within cycle budget", name);
  endtask

  // Memory responder: acks lat cycles after the request is first seen.
  initial begin
    int cnt = 0;
    int lat = 1;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      mif.mem_ack = 1'b0;
      if (inject_ack) begin
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = {4{32'hDEADBEEF}};
        inject_ack    = 1'b0;
        cnt           = 0;
      end else if (resp_hold || !mif.mem_req) begin
        cnt = 0;
      end else begin
        if (cnt == 0) lat = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 4);
        cnt++;
        if (cnt == lat + 1) begin
          if (mif.mem_we) bmem[mif.mem_addr] = mif.mem_wdata;
          else            mif.mem_rdata = line_of(mif.mem_addr);
          mif.mem_ack = 1'b1;
          cnt         = 0;
        end
      end
    end
  end

  // Compare process: checks outputs against the reference every cycle.
  initial begin
    bit           in_txn = 1'b0;
    bit           t_we = 1'b0;
    bit           prev_ldv = 1'b0;
    int           after_ack = 0;
    logic [31:0]  t_addr = '0;
    logic [127:0] t_wdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_txn    = 1'b0;
        after_ack = 0;
        prev_ldv  = 1'b0;
        ref_mem.delete();
        continue;
      end
      if (ld_valid) begin
        chk("ld_data", ld_data, ref_word(ld_addr));
        chk("ld_req_held", ld_req, 1'b1);
        chk("ld_valid_pulse", prev_ldv, 1'b0);
      end
      prev_ldv = ld_valid;
      if (ld_req) chk("sb_ready_vs_ld", sb_ready, 1'b0);
      if (sb_valid && sb_ready) ref_mem[{sb_entry[63:34], 2'b00}] = sb_entry[31:0];
      if (after_ack == 1)      chk("req_drop", mif.mem_req, 1'b0);
      else if (after_ack == 2) chk("wb_to_fill", {mif.mem_req, mif.mem_we}, 2'b10);
      after_ack = 0;
      if (mif.mem_req && !in_txn) begin
        in_txn  = 1'b1;
        t_we    = mif.mem_we;
        t_addr  = mif.mem_addr;
        t_wdata = mif.mem_wdata;
        txn_q.push_back('{we: mif.mem_we, addr: mif.mem_addr, wdata: mif.mem_wdata});
        chk("mem_align", mif.mem_addr[3:0], 4'h0);
        if (mif.mem_we) begin
          for (int k = 0; k < 4; k++)
            chk("wb_data", mif.mem_wdata[32*k +: 32], ref_word(mif.mem_addr + 32'(4*k)));
        end
      end else if (in_txn) begin
        chk("req_held", mif.mem_req, 1'b1);
        chk("addr_stable", {mif.mem_we, mif.mem_addr}, {t_we, t_addr});
        if (t_we) chk("wdata_stable", mif.mem_wdata, t_wdata);
      end else begin
        chk("idle_we", mif.mem_we, 1'b0);
      end
      if (in_txn && mif.mem_ack) begin
        in_txn    = 1'b0;
        after_ack = t_we ? 2 : 1;
      end
    end
  end

  // Tasks are entered just after a rising edge and return just after one.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, output int unsigned acc_cyc);
    int n = 0;
    acc_cyc  = 0;
    sb_entry = {a, d};
    sb_valid = 1'b1;
    forever begin
      @(negedge clk);
      n++;
      if (sb_ready) begin
        acc_cyc = cyc;
        break;
      end
      if (n > 400) begin
        timeout_fail("store_accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    sb_valid = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, output logic [31:0] d, output int n,
                         output int unsigned v_cyc);
    n       = 0;
    d       = '0;
    v_cyc   = 0;
    ld_addr = a;
    ld_req  = 1'b1;
    forever begin
      @(negedge clk);
      n++;
      if (ld_valid) begin
        d     = ld_data;
        v_cyc = cyc;
        break;
      end
      if (n > 400) begin
        timeout_fail("load_valid");
        break;
      end
    end
    @(posedge clk);
    #1;
    ld_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] a1;
    logic [31:0] a2;
    int          n;
    int          found;
    int unsigned vc;
    int unsigned ac;
    int unsigned r;

    bmem[32'h40] = {32'h33330003, 32'h22220002, 32'hCAFEF00D, 32'h11110001};

    // Reset held for two cycles, then idle.
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ld_valid", ld_valid, 1'b0);
    chk("rst_ld_data", ld_data, 32'h0);
    chk("rst_mem_req", mif.mem_req, 1'b0);
    chk("rst_mem_we", mif.mem_we, 1'b0);
    chk("rst_mem_addr", mif.mem_addr, 32'h0);
    chk("rst_sb_ready", sb_ready, 1'b1);
    @(posedge clk);
    #1;

    // Clean load miss with a 3-cycle memory, then a hit in the same line.
    txn_q.delete();
    do_load(32'h40, d, n, vc);
    chk("miss_txn_count", txn_q.size(), 1);
    if (txn_q.size() >= 1) chk("miss_fill_req", {txn_q[0].we, txn_q[0].addr}, {1'b0, 32'h40});
    chk("miss_latency", n, 7);
    chk("miss_data", d, 32'h11110001);
    do_load(32'h44, d, n, vc);
    chk("hit_latency", n, 2);
    chk("hit_data", d, 32'hCAFEF00D);

    // Store hit followed by a load of the same word.
    do_store(32'h44, 32'h12345678, ac);
    do_load(32'h44, d, n, vc);
    chk("st_ld_timing", vc - ac, 3);
    chk("st_ld_data", d, 32'h12345678);

    // Dirty eviction: same index, tag 0.
    txn_q.delete();
    do_load(32'h00, d, n, vc);
    chk("evict_txn_count", txn_q.size(), 2);
    if (txn_q.size() >= 2) begin
      chk("evict_wb_req", {txn_q[0].we, txn_q[0].addr}, {1'b1, 32'h40});
      chk("evict_wb_word1", txn_q[0].wdata[63:32], 32'h12345678);
      chk("evict_fill_req", {txn_q[1].we, txn_q[1].addr}, {1'b0, 32'h00});
    end

    // Simultaneous load and store offer: the load is served first.
    fork
      do_load(32'h00, d, n, vc);
      do_store(32'h08, 32'hA5A50008, ac);
    join
    chk("load_before_store", ac > vc, 1'b1);
    do_load(32'h08, d, n, vc);
    chk("sim_store_data", d, 32'hA5A50008);

    // Reset while a fill is outstanding; the late ack must be ignored.
    resp_hold = 1'b1;
    ld_addr   = 32'h10;
    ld_req    = 1'b1;
    found     = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mif.mem_req) begin
        found = 1;
        break;
      end
    end
    if (found == 0) timeout_fail("midfill_req");
    chk("midfill_is_fill", mif.mem_we, 1'b0);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    ld_req = 1'b0;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    inject_ack = 1'b1;
    @(negedge clk);
    chk("late_ack_req", mif.mem_req, 1'b0);
    chk("late_ack_sb_ready", sb_ready, 1'b1);
    @(negedge clk);
    chk("after_late_ack_req", mif.mem_req, 1'b0);
    chk("after_late_ack_ldv", ld_valid, 1'b0);
    resp_hold = 1'b0;
    txn_q.delete();
    @(posedge clk);
    #1;
    do_load(32'h10, d, n, vc);
    chk("reload_txn_count", txn_q.size(), 1);
    if (txn_q.size() >= 1) chk("reload_fill_req", {txn_q[0].we, txn_q[0].addr}, {1'b0, 32'h10});

    // Randomized traffic with random memory latency.
    lat_fixed = 0;
    for (int i = 0; i < 300; i++) begin
      r  = $urandom_range(0, 9);
      a1 = ($urandom_range(0, 511) & 32'h1FC) | 32'($urandom_range(0, 3));
      a2 = ($urandom_range(0, 511) & 32'h1FC) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a1 = a1 | 32'h80000000;
      if (r < 5) begin
        do_load(a1, d, n, vc);
      end else if (r < 8) begin
        do_store(a1, $urandom, ac);
      end else begin
        fork
          do_load(a1, d, n, vc);
          do_store(a2, $urandom, ac);
        join
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
